hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: ID/EX field widths, register-zero constant
// and the hazard controller state encoding.
package hazard_ctrl_pkg;

   // Register specifier width carried in IF/ID and ID/EX
   localparam int unsigned REG_W = 5;

   // Writes to register 0 are discarded, so it can never carry a dependency
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StStall = 1'b1
   } hzState_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [Width-1:0] count
);

   // Count events, stick at all-ones, clear takes priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and branch flush control for the 5-stage pipeline, with
// saturating counters of stall and flush cycles.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IDEX_MemRead,
   input  logic [REG_W-1:0] IDEX_RtReg,
   input  logic [REG_W-1:0] IFID_RsReg,
   input  logic [REG_W-1:0] IFID_RtReg,
   input  logic             IFID_UsesRt,
   input  logic             EX_BranchTaken,
   input  logic             CntClear,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // First RUN cycle of a hazard is itself a bubble, so STALL covers the rest
   localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

   hzState_t   stateQ, stateD;
   logic [1:0] stallLeftQ, stallLeftD;
   logic       hazard;

   assign hazard = IDEX_MemRead & (IDEX_RtReg != REG_ZERO) &
                   ((IDEX_RtReg == IFID_RsReg) |
                    (IFID_UsesRt & (IDEX_RtReg == IFID_RtReg)));

   // State and remaining-bubble register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ     <= StRun;
         stallLeftQ <= 2'd0;
      end else begin
         stateQ     <= stateD;
         stallLeftQ <= stallLeftD;
      end
   end

   // Mealy next-state and pipeline control; reset masks every input
   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXFlush  = 1'b0;
      stateD     = stateQ;
      stallLeftD = stallLeftQ;
      if (!rst_n) begin
         stateD     = StRun;
         stallLeftD = 2'd0;
      end else if (EX_BranchTaken) begin
         // Wrong-path instructions in IF/ID and ID make any stall moot
         IFIDFlush  = 1'b1;
         IDEXFlush  = 1'b1;
         stateD     = StRun;
         stallLeftD = 2'd0;
      end else begin
         case (stateQ)
            StRun: begin
               if (hazard) begin
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXFlush = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     stateD     = StStall;
                     stallLeftD = STALL_INIT;
                  end
               end
            end
            StStall: begin
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               IDEXFlush  = 1'b1;
               stallLeftD = stallLeftQ - 2'd1;
               if (stallLeftQ <= 2'd1) begin
                  stateD     = StRun;
                  stallLeftD = 2'd0;
               end
            end
            default: begin
               stateD     = StRun;
               stallLeftD = 2'd0;
            end
         endcase
      end
   end

   sat_counter #(
      .Width (CNT_W)
   ) uStallCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~IFIDWrite),
      .clr   (CntClear),
      .count (StallCount)
   );

   sat_counter #(
      .Width (CNT_W)
   ) uFlushCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (IFIDFlush),
      .clr   (CntClear),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three hazard_ctrl instances (1-cycle stall, 3-cycle stall,
// 4-bit counters) driven from one shared set of inputs.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       memRead;
   logic [4:0] exRt, idRs, idRt;
   logic       usesRt, brTaken, cntClr;

   logic        pc1, ifw1, iff1, idf1;
   logic [15:0] sc1, fc1;
   logic        pc3, ifw3, iff3, idf3;
   logic [15:0] sc3, fc3;
   logic        pc4, ifw4, iff4, idf4;
   logic [3:0]  sc4, fc4;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .IDEX_MemRead(memRead), .IDEX_RtReg(exRt),
      .IFID_RsReg(idRs), .IFID_RtReg(idRt), .IFID_UsesRt(usesRt),
      .EX_BranchTaken(brTaken), .CntClear(cntClr), .PCWrite(pc1), .IFIDWrite(ifw1),
      .IFIDFlush(iff1), .IDEXFlush(idf1), .StallCount(sc1), .FlushCount(fc1));

   hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .IDEX_MemRead(memRead), .IDEX_RtReg(exRt),
      .IFID_RsReg(idRs), .IFID_RtReg(idRt), .IFID_UsesRt(usesRt),
      .EX_BranchTaken(brTaken), .CntClear(cntClr), .PCWrite(pc3), .IFIDWrite(ifw3),
      .IFIDFlush(iff3), .IDEXFlush(idf3), .StallCount(sc3), .FlushCount(fc3));

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .IDEX_MemRead(memRead), .IDEX_RtReg(exRt),
      .IFID_RsReg(idRs), .IFID_RtReg(idRt), .IFID_UsesRt(usesRt),
      .EX_BranchTaken(brTaken), .CntClear(cntClr), .PCWrite(pc4), .IFIDWrite(ifw4),
      .IFIDFlush(iff4), .IDEXFlush(idf4), .StallCount(sc4), .FlushCount(fc4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic m, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rtId, input logic u, input logic br,
                        input logic clr);
      memRead = m; exRt = rt; idRs = rs; idRt = rtId;
      usesRt = u; brTaken = br; cntClr = clr;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges, leaving inputs idle
   task automatic doReset();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // Reset with a live hazard and branch on the inputs: all must be masked
      rst_n = 1'b0;
      drive(1, 5, 5, 0, 0, 1, 0);
      #2;
      chk("rst_pcwrite", 32'(pc1), 1);
      chk("rst_ifidwrite", 32'(ifw1), 1);
      chk("rst_ifidflush", 32'(iff1), 0);
      chk("rst_idexflush", 32'(idf1), 0);
      chk("rst_stallcnt", 32'(sc1), 0);
      chk("rst_flushcnt", 32'(fc3), 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      tick();

      // Single-cycle load-use stall
      drive(1, 5, 5, 0, 0, 0, 0);
      #1;
      chk("ls1_pcwrite", 32'(pc1), 0);
      chk("ls1_ifidwrite", 32'(ifw1), 0);
      chk("ls1_idexflush", 32'(idf1), 1);
      chk("ls1_ifidflush", 32'(iff1), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("ls1_run_pcwrite", 32'(pc1), 1);
      chk("ls1_run_idexflush", 32'(idf1), 0);
      chk("ls1_stallcnt", 32'(sc1), 1);

      // Three-cycle stall with the hazard held throughout
      doReset();
      drive(1, 9, 9, 0, 0, 0, 0);
      #1;
      chk("ls3_c1_pcwrite", 32'(pc3), 0);
      tick();
      chk("ls3_c2_pcwrite", 32'(pc3), 0);
      chk("ls3_c2_idexflush", 32'(idf3), 1);
      chk("ls3_c2_ifidflush", 32'(iff3), 0);
      tick();
      chk("ls3_c3_ifidwrite", 32'(ifw3), 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("ls3_run_pcwrite", 32'(pc3), 1);
      chk("ls3_run_idexflush", 32'(idf3), 0);
      chk("ls3_stallcnt", 32'(sc3), 3);

      // Register zero never hazards; Rt match only counts when Rt is read
      doReset();
      drive(1, 0, 0, 0, 1, 0, 0);
      #1;
      chk("r0_pcwrite", 32'(pc1), 1);
      chk("r0_idexflush", 32'(idf1), 0);
      drive(1, 7, 3, 7, 0, 0, 0);
      #1;
      chk("rt_nouse_pcwrite", 32'(pc1), 1);
      drive(1, 7, 3, 7, 1, 0, 0);
      #1;
      chk("rt_use_pcwrite", 32'(pc1), 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("nohaz_stallcnt", 32'(sc1), 0);

      // Branch beats a simultaneous hazard
      doReset();
      drive(1, 5, 5, 0, 0, 1, 0);
      #1;
      chk("br_ifidflush", 32'(iff3), 1);
      chk("br_idexflush", 32'(idf3), 1);
      chk("br_pcwrite", 32'(pc3), 1);
      chk("br_ifidwrite", 32'(ifw3), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("br_after_pcwrite", 32'(pc3), 1);
      chk("br_flushcnt", 32'(fc3), 1);
      chk("br_stallcnt", 32'(sc3), 0);

      // Branch arriving mid-stall ends the stall
      doReset();
      drive(1, 5, 5, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0);
      #1;
      chk("stbr_pcwrite", 32'(pc3), 1);
      chk("stbr_ifidflush", 32'(iff3), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("stbr_run_pcwrite", 32'(pc3), 1);
      chk("stbr_stallcnt", 32'(sc3), 1);
      chk("stbr_flushcnt", 32'(fc3), 1);

      // Reset during the second stall cycle takes effect without a clock
      doReset();
      drive(1, 5, 5, 0, 0, 0, 0);
      tick();
      chk("rs_mid_pcwrite", 32'(pc3), 0);
      rst_n = 1'b0;
      #1;
      chk("rs_pcwrite", 32'(pc3), 1);
      chk("rs_idexflush", 32'(idf3), 0);
      chk("rs_stallcnt", 32'(sc3), 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rs_post_pcwrite", 32'(pc3), 1);
      chk("rs_post_stallcnt", 32'(sc3), 0);

      // Counter saturation and clear priority
      doReset();
      drive(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_flushcnt4", 32'(fc4), 15);
      chk("sat_flushcnt16", 32'(fc1), 20);
      chk("sat_stallcnt4", 32'(sc4), 0);
      drive(0, 0, 0, 0, 0, 1, 1);
      tick();
      chk("clr_flushcnt4", 32'(fc4), 0);
      chk("clr_flushcnt16", 32'(fc1), 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      chk("clr_then_inc", 32'(fc4), 1);
      drive(1, 4, 4, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stallcnt4b", 32'(sc4), 15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
